ascon_bdi_packer: RTL and testbench

ASCON_BDI_PACKER -- requirements
Module: ascon_bdi_packer

---
 rtl/ascon_bdi_packer.sv | 118 +++++++++++
 tb/tb_ascon_bdi_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_bdi_packer.sv
// Byte-to-word packer for the Ascon core's BDI port. Collects up to four bytes of a
// segment into one CCW-bit word, with a keep mask and type/eot/eoi sideband.
module ascon_bdi_packer #(
    parameter int CCW = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     s_data,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [3:0]     s_type,
    input  logic           s_eot,
    input  logic           s_eoi,
    output logic [CCW-1:0] bdi,
    output logic           bdi_valid,
    input  logic           bdi_ready,
    output logic [3:0]     bdi_type,
    output logic           bdi_eot,
    output logic           bdi_eoi,
    output logic [3:0]     bdi_keep,
    output logic           err
);
    localparam int LANES = CCW / 8;

    // Accumulator: lanes below cnt_q hold bytes already collected, the rest are zero.
    logic [LANES-2:0][7:0] acc_q, acc_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [3:0]            type_q, type_d;

    logic [LANES-1:0][7:0] word_q, word_d;
    logic [3:0]            keep_q, keep_d;
    logic [3:0]            otype_q, otype_d;
    logic                  eot_q, eot_d;
    logic                  eoi_q, eoi_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic accept, complete, first, type_err, eoi_err;

    assign s_ready  = !valid_q | bdi_ready;
    assign accept   = s_valid & s_ready;
    assign first    = (cnt_q == 2'd0);
    assign complete = accept & ((cnt_q == 2'(LANES-1)) | s_eot);
    assign type_err = !first & (s_type != type_q);
    assign eoi_err  = s_eoi & !s_eot;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam logic [1:0] LJ = 2'(j);
        if (j < LANES - 1) begin : g_acc
            assign word_d[j] = (cnt_q == LJ) ? s_data : (cnt_q > LJ) ? acc_q[j] : 8'h00;
            assign acc_d[j]  = complete ? 8'h00 :
                               (accept && cnt_q == LJ) ? s_data : acc_q[j];
        end else begin : g_top
            assign word_d[j] = (cnt_q == LJ) ? s_data : 8'h00;
        end
        assign keep_d[j] = (cnt_q >= LJ);
    end

    always_comb begin
        cnt_d   = cnt_q;
        type_d  = type_q;
        otype_d = otype_q;
        eot_d   = eot_q;
        eoi_d   = eoi_q;
        valid_d = valid_q;
        err_d   = err_q | (accept & (type_err | eoi_err));
        if (valid_q && bdi_ready)
            valid_d = 1'b0;
        if (complete) begin
            cnt_d   = 2'd0;
            otype_d = first ? s_type : type_q;
            eot_d   = s_eot;
            eoi_d   = s_eoi;
            valid_d = 1'b1;
        end else if (accept) begin
            cnt_d = cnt_q + 2'd1;
            if (first)
                type_d = s_type;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            type_q  <= '0;
            word_q  <= '0;
            keep_q  <= '0;
            otype_q <= '0;
            eot_q   <= 1'b0;
            eoi_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            otype_q <= otype_d;
            eot_q   <= eot_d;
            eoi_q   <= eoi_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            // Output word only moves on a completing byte, so it holds while stalled.
            if (complete) begin
                word_q <= word_d;
                keep_q <= keep_d;
            end
        end
    end

    assign bdi       = word_q;
    assign bdi_keep  = keep_q;
    assign bdi_type  = otype_q;
    assign bdi_eot   = eot_q;
    assign bdi_eoi   = eoi_q;
    assign bdi_valid = valid_q;
    assign err       = err_q;
endmodule

// File: tb/tb_ascon_bdi_packer.sv
// Scoreboard bench for ascon_bdi_packer: directed byte streams, expected words queued
// at issue time and checked by a monitor whenever a word handshake occurs.
module tb_ascon_bdi_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  s_type = '0;
    logic        s_eot = 1'b0;
    logic        s_eoi = 1'b0;
    logic [31:0] bdi;
    logic        bdi_valid;
    logic        bdi_ready = 1'b1;
    logic [3:0]  bdi_type;
    logic        bdi_eot;
    logic        bdi_eoi;
    logic [3:0]  bdi_keep;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // {data, keep, type, eot, eoi}
    logic [41:0] exp_q[$];
    int          pop_cyc[$];

    ascon_bdi_packer #(.CCW(32)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_type(s_type), .s_eot(s_eot), .s_eoi(s_eoi),
        .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
        .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
        .bdi_keep(bdi_keep), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic [3:0] t,
                            input logic eot, input logic eoi);
        exp_q.push_back({d, k, t, eot, eoi});
    endtask

    // Monitor: every word transfer is popped against the scoreboard; stalled words must hold.
    logic        held = 1'b0;
    logic [41:0] held_v;
    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else begin
            if (held && bdi_valid)
                chk("stall_hold", 64'({bdi, bdi_keep, bdi_type, bdi_eot, bdi_eoi}), 64'(held_v));
            held = 1'b0;
            if (bdi_valid && bdi_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(bdi), 64'hDEAD_0000_0000);
                end else begin
                    chk("word", 64'({bdi, bdi_keep, bdi_type, bdi_eot, bdi_eoi}),
                        64'(exp_q.pop_front()));
                    pop_cyc.push_back(cyc);
                end
            end else if (bdi_valid) begin
                held   = 1'b1;
                held_v = {bdi, bdi_keep, bdi_type, bdi_eot, bdi_eoi};
            end
        end
    end

    // Present one byte and hold it until an edge where s_ready was high.
    task automatic send(input logic [7:0] d, input logic [3:0] t, input logic eot, input logic eoi);
        bit done = 0;
        s_data = d; s_type = t; s_eot = eot; s_eoi = eoi; s_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (s_ready) done = 1;
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 64'(d), 64'hFFFF);
    endtask

    task automatic idle();
        s_valid = 1'b0; s_eot = 1'b0; s_eoi = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("rst_valid", 64'(bdi_valid), 64'd0);
        chk("rst_out", 64'({bdi, bdi_keep, bdi_type, bdi_eot, bdi_eoi, err}), 64'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    int stall_sready_bad;

    initial begin
        // Reset state
        #3;
        chk("reset_valid", 64'(bdi_valid), 64'd0);
        chk("reset_out", 64'({bdi, bdi_keep, bdi_type, bdi_eot, bdi_eoi, err}), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;

        // 16 bytes of one segment at full rate
        pop_cyc.delete();
        push_exp(32'h03020100, 4'b1111, 4'h1, 0, 0);
        push_exp(32'h07060504, 4'b1111, 4'h1, 0, 0);
        push_exp(32'h0B0A0908, 4'b1111, 4'h1, 0, 0);
        push_exp(32'h0F0E0D0C, 4'b1111, 4'h1, 1, 1);
        for (int i = 0; i < 16; i++)
            send(8'(i), 4'h1, i == 15, i == 15);
        idle();
        drain();
        chk("rate_words", 64'(pop_cyc.size()), 64'd4);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("rate_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd4);

        // Partial word, 3 bytes
        push_exp(32'h00CCBBAA, 4'b0111, 4'h2, 1, 0);
        send(8'hAA, 4'h2, 0, 0);
        send(8'hBB, 4'h2, 0, 0);
        send(8'hCC, 4'h2, 1, 0);
        idle();
        drain();

        // Single byte, type taken straight from the byte
        push_exp(32'h0000005A, 4'b0001, 4'hD, 1, 1);
        send(8'h5A, 4'hD, 1, 1);
        idle();
        drain();
        chk("err_clean", 64'(err), 64'd0);

        // Back-pressure: ready drops for 10 cycles once the first word is up
        push_exp(32'h23222120, 4'b1111, 4'h3, 0, 0);
        push_exp(32'h27262524, 4'b1111, 4'h3, 0, 0);
        push_exp(32'h2B2A2928, 4'b1111, 4'h3, 1, 1);
        stall_sready_bad = 0;
        fork
            for (int i = 0; i < 12; i++)
                send(8'h20 + 8'(i), 4'h3, i == 11, i == 11);
            begin
                bit seen = 0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(posedge clk); #1;
                    seen = bdi_valid;
                end
                chk("stall_word_seen", 64'(seen), 64'd1);
                bdi_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (s_ready) stall_sready_bad++;
                end
                @(posedge clk); #1;
                bdi_ready = 1'b1;
            end
        join
        idle();
        drain();
        chk("stall_s_ready_low", 64'(stall_sready_bad), 64'd0);

        // Reset mid-word, then reset with a word pending: neither may surface
        send(8'h01, 4'h1, 0, 0);
        send(8'h02, 4'h1, 0, 0);
        idle();
        do_reset();
        bdi_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h90 + 8'(i), 4'h1, 0, 0);
        idle();
        chk("pending_valid", 64'(bdi_valid), 64'd1);
        do_reset();
        bdi_ready = 1'b1;
        push_exp(32'h44332211, 4'b1111, 4'h1, 1, 1);
        send(8'h11, 4'h1, 0, 0);
        send(8'h22, 4'h1, 0, 0);
        send(8'h33, 4'h1, 0, 0);
        send(8'h44, 4'h1, 1, 1);
        idle();
        drain();
        chk("err_after_rst", 64'(err), 64'd0);

        // Type change mid-word: flagged, word keeps the first byte's type
        push_exp(32'h00030201, 4'b0111, 4'h1, 1, 1);
        send(8'h01, 4'h1, 0, 0);
        send(8'h02, 4'h1, 0, 0);
        chk("err_before_mix", 64'(err), 64'd0);
        send(8'h03, 4'h2, 1, 1);
        idle();
        drain();
        chk("err_type_mix", 64'(err), 64'd1);
        push_exp(32'h000000E1, 4'b0001, 4'h4, 1, 0);
        send(8'hE1, 4'h4, 1, 0);
        idle();
        drain();
        chk("err_sticky", 64'(err), 64'd1);

        // eoi without eot: flagged, byte packed as a normal non-final byte
        do_reset();
        push_exp(32'h7A797877, 4'b1111, 4'h5, 1, 1);
        send(8'h77, 4'h5, 0, 1);
        idle();
        @(negedge clk);
        chk("err_eoi_no_eot", 64'(err), 64'd1);
        chk("eoi_no_complete", 64'(bdi_valid), 64'd0);
        @(posedge clk); #1;
        send(8'h78, 4'h5, 0, 0);
        send(8'h79, 4'h5, 0, 0);
        send(8'h7A, 4'h5, 1, 1);
        idle();
        drain();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
